// File: rtl/stream_relay_ctrl_if.sv
// Start/idle handshake between the relay controller and the stream stages.
interface stream_relay_ctrl_if #(
  parameter int unsigned N_STAGES = 4
);
  logic [N_STAGES-1:0] stage_start;
  logic [N_STAGES-1:0] stage_idle;

  modport master (output stage_start, input stage_idle);
  modport slave  (input stage_start, output stage_idle);
endinterface

// File: rtl/stream_relay_ctrl.sv
// Button debouncer: 2-flop sync, stability counter, registered rising-edge pulse.
module stream_relay_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count stable cycles, flip level, and pulse on its rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// Sequencer that launches each stream stage in turn, counts laps and traps hangs.
module stream_relay_ctrl #(
  parameter int unsigned N_STAGES      = 4,
  parameter int unsigned DEBOUNCE_CYC  = 1000000,
  parameter int unsigned ACK_TIMEOUT   = 8,
  parameter int unsigned STAGE_TIMEOUT = 500000000,
  parameter int unsigned LAPS          = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_start,
  input  logic                        btn_stop,
  stream_relay_ctrl_if.master         chain,
  output logic [$clog2(N_STAGES)-1:0] active_stage,
  output logic [7:0]                  lap_count,
  output logic                        busy,
  output logic                        fault
);
  localparam int unsigned IDX_W   = $clog2(N_STAGES);
  localparam int unsigned TIMER_W = 29;
  localparam int unsigned LAP_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE, S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAP_W-1:0]    lap_q, lap_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [N_STAGES-1:0] stage_start_q, stage_start_d;
  logic                busy_d;
  logic                fault_d;
  logic                start_press;
  logic                stop_press;

  stream_relay_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_press)
  );

  stream_relay_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_stop),
    .press (stop_press)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      lap_q         <= '0;
      timer_q       <= '0;
      stage_start_q <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lap_q         <= lap_d;
      timer_q       <= timer_d;
      stage_start_q <= stage_start_d;
      busy          <= busy_d;
      fault         <= fault_d;
    end
  end

  // Next state, stage index, lap count and per-state timer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lap_d   = lap_q;
    timer_d = '0;
    case (state_q)
      S_IDLE: begin
        if (start_press && !stop_press && (&chain.stage_idle)) begin
          idx_d   = '0;
          lap_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = stop_press ? S_IDLE : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (stop_press) begin
          state_d = S_IDLE;
        end else if (!chain.stage_idle[idx_q]) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_WAIT_DONE: begin
        if (stop_press) begin
          state_d = S_IDLE;
        end else if (chain.stage_idle[idx_q]) begin
          state_d = S_ADVANCE;
        end else if (timer_q == TIMER_W'(STAGE_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
      end
      S_ADVANCE: begin
        if (stop_press) begin
          state_d = S_IDLE;
        end else if (idx_q != IDX_W'(N_STAGES - 1)) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LAUNCH;
        end else begin
          idx_d   = '0;
          lap_d   = lap_q + 1'b1;
          state_d = ((LAPS != 0) && (lap_d == LAP_W'(LAPS))) ? S_IDLE : S_LAUNCH;
        end
      end
      S_FAULT: begin
        if (start_press && !stop_press) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timer runs only while waiting in the same state; any entry clears it.
    if ((state_d == state_q) && ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE))) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    stage_start_d = '0;
    busy_d        = 1'b0;
    fault_d       = 1'b0;
    if (state_d == S_LAUNCH) begin
      stage_start_d[idx_d] = 1'b1;
    end
    busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
    fault_d = (state_d == S_FAULT);
  end

  assign chain.stage_start = stage_start_q;
  assign active_stage      = idx_q;
  assign lap_count         = lap_q;
endmodule

// File: tb/tb_stream_relay_ctrl.sv
// Directed bench for stream_relay_ctrl with stub stages.
module tb_stream_relay_ctrl;
  localparam int unsigned N  = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned AT = 8;
  localparam int unsigned ST = 100;
  localparam int unsigned LP = 2;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop  = 1'b0;
  logic [1:0] active_stage;
  logic [7:0] lap_count;
  logic       busy;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  stream_relay_ctrl_if #(.N_STAGES(N)) chain ();

  stream_relay_ctrl #(
    .N_STAGES(N), .DEBOUNCE_CYC(DB), .ACK_TIMEOUT(AT), .STAGE_TIMEOUT(ST), .LAPS(LP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_start    (btn_start),
    .btn_stop     (btn_stop),
    .chain        (chain),
    .active_stage (active_stage),
    .lap_count    (lap_count),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub stages: drop idle 2 cycles after the pulse, raise it 20 cycles later.
  logic [N-1:0] never_drop = '0;
  logic [N-1:0] never_rise = '0;
  logic [N-1:0] force_busy = '0;
  logic [N-1:0] stub_idle  = '1;
  logic [N-1:0] stub_run   = '0;
  int           stub_cnt [N];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      stub_idle = '1;
      stub_run  = '0;
      for (int i = 0; i < N; i++) stub_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (chain.stage_start[i] === 1'b1) begin
          stub_cnt[i] = 0;
          stub_run[i] = 1'b1;
        end else if (stub_run[i]) begin
          stub_cnt[i] = stub_cnt[i] + 1;
          if (stub_cnt[i] == 2 && !never_drop[i]) stub_idle[i] = 1'b0;
          if (stub_cnt[i] == 22 && !never_rise[i]) begin
            stub_idle[i] = 1'b1;
            stub_run[i]  = 1'b0;
          end
        end
      end
    end
  end

  assign chain.stage_idle = stub_idle & ~force_busy;

  // Log of every start pulse seen: cycle and raw vector.
  int           pulse_cyc [$];
  logic [N-1:0] pulse_vec [$];

  always @(negedge clk) begin
    if (chain.stage_start !== '0) begin
      pulse_cyc.push_back(cyc);
      pulse_vec.push_back(chain.stage_start);
    end
  end

  task automatic hold_start(input int len, output int b);
    @(negedge clk);
    btn_start = 1'b1;
    b = cyc;
    repeat (len) @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_pulses(input int n, output bit ok);
    int budget = 2000;
    while (pulse_cyc.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (pulse_cyc.size() >= n);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL pulse_wait: got %0d pulses required %0d", pulse_cyc.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (chain.stage_start !== 3'b000) begin n_err++; $display("FAIL rst_start: got %b required 000", chain.stage_start); end
    n_cmp++; if (active_stage !== 2'd0) begin n_err++; $display("FAIL rst_active: got %0d required 0", active_stage); end
    n_cmp++; if (lap_count !== 8'd0) begin n_err++; $display("FAIL rst_lap: got %0d required 0", lap_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b required 0", fault); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_run();
    int b, p0, base;
    bit ok;
    logic [N-1:0] exp_vec;
    repeat (10) @(negedge clk);
    base = pulse_cyc.size();
    hold_start(10, b);
    wait_pulses(base + 1, ok);
    if (ok) begin
      p0 = pulse_cyc[base];
      n_cmp++; if (p0 !== b + 8) begin n_err++; $display("FAIL run_latency: got cycle %0d required %0d", p0, b + 8); end
      wait_until(p0 + 72);
      n_cmp++; if (lap_count !== 8'd1) begin n_err++; $display("FAIL run_lap_mid: got %0d required 1", lap_count); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy_mid: got %b required 1", busy); end
      wait_until(p0 + 143);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy_advance: got %b required 1", busy); end
      wait_until(p0 + 144);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_busy_end: got %b required 0", busy); end
      n_cmp++; if (lap_count !== 8'd2) begin n_err++; $display("FAIL run_lap_end: got %0d required 2", lap_count); end
      n_cmp++; if (active_stage !== 2'd0) begin n_err++; $display("FAIL run_active_end: got %0d required 0", active_stage); end
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL run_fault_end: got %b required 0", fault); end
      wait_until(p0 + 180);
      n_cmp++; if (pulse_cyc.size() !== base + 6) begin n_err++; $display("FAIL run_pulse_count: got %0d required %0d", pulse_cyc.size() - base, 6); end
      for (int k = 0; k < 6; k++) begin
        exp_vec = 3'b001 << (k % 3);
        n_cmp++; if (pulse_vec[base + k] !== exp_vec) begin n_err++; $display("FAIL run_pulse_vec%0d: got %b required %b", k, pulse_vec[base + k], exp_vec); end
        n_cmp++; if (pulse_cyc[base + k] !== p0 + 24 * k) begin n_err++; $display("FAIL run_pulse_cyc%0d: got %0d required %0d", k, pulse_cyc[base + k], p0 + 24 * k); end
      end
    end
  endtask

  task automatic test_glitch();
    int b, base;
    repeat (10) @(negedge clk);
    base = pulse_cyc.size();
    hold_start(3, b);
    wait_until(b + 25);
    n_cmp++; if (pulse_cyc.size() !== base) begin n_err++; $display("FAIL glitch_pulses: got %0d required 0", pulse_cyc.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b required 0", busy); end
    n_cmp++; if (lap_count !== 8'd2) begin n_err++; $display("FAIL glitch_lap: got %0d required 2", lap_count); end
  endtask

  task automatic test_ack_timeout();
    int b, p1, base;
    bit ok;
    repeat (10) @(negedge clk);
    never_drop = 3'b010;
    base = pulse_cyc.size();
    hold_start(6, b);
    wait_pulses(base + 2, ok);
    if (ok) begin
      p1 = pulse_cyc[base + 1];
      n_cmp++; if (pulse_vec[base + 1] !== 3'b010) begin n_err++; $display("FAIL ack_vec: got %b required 010", pulse_vec[base + 1]); end
      wait_until(p1 + 8);
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL ack_fault_early: got %b required 0", fault); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ack_busy_early: got %b required 1", busy); end
      wait_until(p1 + 9);
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL ack_fault: got %b required 1", fault); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ack_busy: got %b required 0", busy); end
      n_cmp++; if (active_stage !== 2'd1) begin n_err++; $display("FAIL ack_active: got %0d required 1", active_stage); end
      never_drop = '0;
      repeat (10) @(negedge clk);
      hold_start(6, b);
      wait_until(b + 14);
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL ack_clear_fault: got %b required 0", fault); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ack_clear_busy: got %b required 0", busy); end
      n_cmp++; if (pulse_cyc.size() !== base + 2) begin n_err++; $display("FAIL ack_clear_pulses: got %0d required 2", pulse_cyc.size() - base); end
    end
    never_drop = '0;
  endtask

  task automatic test_done_timeout();
    int b, p2, base;
    bit ok;
    repeat (20) @(negedge clk);
    never_rise = 3'b100;
    base = pulse_cyc.size();
    hold_start(6, b);
    wait_pulses(base + 3, ok);
    if (ok) begin
      p2 = pulse_cyc[base + 2];
      n_cmp++; if (pulse_vec[base + 2] !== 3'b100) begin n_err++; $display("FAIL done_vec: got %b required 100", pulse_vec[base + 2]); end
      wait_until(p2 + 102);
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL done_fault_early: got %b required 0", fault); end
      wait_until(p2 + 103);
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL done_fault: got %b required 1", fault); end
      n_cmp++; if (lap_count !== 8'd0) begin n_err++; $display("FAIL done_lap: got %0d required 0", lap_count); end
      n_cmp++; if (active_stage !== 2'd2) begin n_err++; $display("FAIL done_active: got %0d required 2", active_stage); end
      hold_start(6, b);
      wait_until(b + 14);
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL done_clear_fault: got %b required 0", fault); end
      n_cmp++; if (pulse_cyc.size() !== base + 3) begin n_err++; $display("FAIL done_clear_pulses: got %0d required 3", pulse_cyc.size() - base); end
    end
    never_rise = '0;
    do_reset();
  endtask

  task automatic test_stop();
    int b, p1, base;
    bit ok;
    repeat (10) @(negedge clk);
    base = pulse_cyc.size();
    hold_start(6, b);
    wait_pulses(base + 2, ok);
    if (ok) begin
      p1 = pulse_cyc[base + 1];
      wait_until(p1 + 4);
      btn_stop = 1'b1;
      wait_until(p1 + 11);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_busy_before: got %b required 1", busy); end
      wait_until(p1 + 12);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy_after: got %b required 0", busy); end
      wait_until(p1 + 20);
      btn_stop = 1'b0;
      wait_until(p1 + 45);
      n_cmp++; if (pulse_cyc.size() !== base + 2) begin n_err++; $display("FAIL stop_pulses: got %0d required 2", pulse_cyc.size() - base); end
      n_cmp++; if (active_stage !== 2'd1) begin n_err++; $display("FAIL stop_active: got %0d required 1", active_stage); end
      n_cmp++; if (lap_count !== 8'd0) begin n_err++; $display("FAIL stop_lap: got %0d required 0", lap_count); end
      // Both buttons rise together: stop must win, nothing launches.
      @(negedge clk);
      btn_start = 1'b1;
      btn_stop  = 1'b1;
      b = cyc;
      repeat (6) @(negedge clk);
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      wait_until(b + 25);
      n_cmp++; if (pulse_cyc.size() !== base + 2) begin n_err++; $display("FAIL stopwins_pulses: got %0d required 2", pulse_cyc.size() - base); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stopwins_busy: got %b required 0", busy); end
    end
    btn_stop = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int b, base;
    repeat (10) @(negedge clk);
    force_busy = 3'b001;
    base = pulse_cyc.size();
    hold_start(6, b);
    wait_until(b + 20);
    n_cmp++; if (pulse_cyc.size() !== base) begin n_err++; $display("FAIL nonidle_pulses: got %0d required 0", pulse_cyc.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nonidle_busy: got %b required 0", busy); end
    force_busy = '0;
  endtask

  task automatic test_reset_mid_launch();
    int b, base, budget;
    bit found, ok;
    repeat (10) @(negedge clk);
    hold_start(6, b);
    found  = 1'b0;
    budget = 40;
    while (!found && budget > 0) begin
      @(negedge clk);
      budget--;
      if (chain.stage_start[0] === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL midrst_launch_seen: got no pulse required stage 0 pulse");
    end else begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_pre: got %b required 1", busy); end
      reset = 1'b0;
      #1;
      n_cmp++; if (chain.stage_start !== 3'b000) begin n_err++; $display("FAIL midrst_start: got %b required 000", chain.stage_start); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b required 0", busy); end
      n_cmp++; if (active_stage !== 2'd0) begin n_err++; $display("FAIL midrst_active: got %0d required 0", active_stage); end
      n_cmp++; if (lap_count !== 8'd0) begin n_err++; $display("FAIL midrst_lap: got %0d required 0", lap_count); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      base = pulse_cyc.size();
      hold_start(6, b);
      wait_pulses(base + 1, ok);
      if (ok) begin
        n_cmp++; if (pulse_cyc[base] !== b + 8) begin n_err++; $display("FAIL midrst_restart_cyc: got %0d required %0d", pulse_cyc[base], b + 8); end
        n_cmp++; if (pulse_vec[base] !== 3'b001) begin n_err++; $display("FAIL midrst_restart_vec: got %b required 001", pulse_vec[base]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_glitch();
    test_ack_timeout();
    test_done_timeout();
    test_stop();
    test_busy_ignore();
    test_reset_mid_launch();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
